// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory initiator. It handles one load or store at a time.
//            Sub-word stores are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int MEM_BYTES        = 1024,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    // Highest address whose 4-byte window still fits in memory.
    // Comparing against this unsigned value makes addresses near 2^32 fail the check.
    localparam logic [31:0] c_MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_funct3;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_f3_bad;
    logic        w_range_bad;
    logic        w_misal;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_f3_bad    = req_store ? (req_funct3 >= 3'd3)
                                   : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    assign w_range_bad = (req_addr > c_MAX_ADDR);
    assign w_misal     = !ALLOW_MISALIGNED &&
                         (((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)));
    assign w_req_err   = w_f3_bad || w_range_bad || w_misal;

    always_comb begin
        w_load_data = mem_rdata;
        case (r_funct3)
            3'd0:    w_load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'd4:    w_load_data = {24'h0, mem_rdata[7:0]};
            3'd1:    w_load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'd5:    w_load_data = {16'h0, mem_rdata[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // The store data replaces the low byte or half of the window. The other bytes keep the values just read.
    assign w_merged = (r_funct3[1:0] == 2'd0) ? {mem_rdata[31:8], r_wdata[7:0]}
                                              : {mem_rdata[31:16], r_wdata[15:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err)                    w_next = S_RESP;
                    else if (!req_store)              w_next = S_RD;
                    else if (req_funct3[1:0] == 2'd2) w_next = S_WR;
                    else                              w_next = S_RMW_RD;
                end
            end
            S_RD: begin
                mem_re = 1'b1;
                w_next = S_RESP;
            end
            S_RMW_RD: begin
                mem_re = 1'b1;
                w_next = S_WR;
            end
            S_WR: begin
                mem_we = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_funct3    <= 3'd0;
            r_wdata     <= 16'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata[15:0];
                        r_err    <= w_req_err;
                        r_rdata  <= 32'h0;
                        // A rejected request leaves the memory-side address and data unchanged.
                        if (!w_req_err) begin
                            r_mem_addr <= req_addr;
                            if (req_store && (req_funct3[1:0] == 2'd2)) begin
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_RD:     r_rdata     <= w_load_data;
                S_RMW_RD: r_mem_wdata <= w_merged;
                default:  ;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit. It includes a byte-array data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid, a_req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_err, mem_we, mem_re;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_we, a_mem_re;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [31:0] a_mem_rdata;

    logic [7:0]  mem [0:1023];
    logic [9:0]  ma;

    int nchk;
    int npass;

    load_store_unit #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_rdata(a_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_mem_rdata = 32'h0;
    assign ma = mem_addr[9:0];
    assign mem_rdata = mem_re ? {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]} : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[ma]         = mem_wdata[7:0];
            mem[ma + 10'd1] = mem_wdata[15:8];
            mem[ma + 10'd2] = mem_wdata[23:16];
            mem[ma + 10'd3] = mem_wdata[31:24];
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request to dut (sel=0) or dut_a (sel=1). It returns the cycle in which the response appears.
    task automatic issue(input bit sel, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output bit saw_re, output bit saw_we, output bit saw_both);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (sel) a_req_valid = 1'b1;
        else     req_valid   = 1'b1;
        step();
        req_valid   = 1'b0;
        a_req_valid = 1'b0;
        lat = 1; saw_re = 0; saw_we = 0; saw_both = 0;
        while (lat < 12) begin
            if (sel ? a_resp_valid : resp_valid) break;
            saw_re   |= sel ? a_mem_re : mem_re;
            saw_we   |= sel ? a_mem_we : mem_we;
            saw_both |= sel ? (a_mem_re && a_mem_we) : (mem_re && mem_we);
            step();
            lat++;
        end
        rd = sel ? a_resp_rdata : resp_rdata;
        er = sel ? a_resp_err : resp_err;
        if (resp_ready) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        nchk++; if (req_ready !== 1'b1)   $display("FAIL rst_req_ready: got %b want 1", req_ready); else npass++;
        nchk++; if (resp_valid !== 1'b0)  $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else npass++;
        nchk++; if (resp_err !== 1'b0)    $display("FAIL rst_resp_err: got %b want 0", resp_err); else npass++;
        nchk++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); else npass++;
        nchk++; if (mem_we !== 1'b0 || mem_re !== 1'b0) $display("FAIL rst_mem_en: got we=%b re=%b want 0/0", mem_we, mem_re); else npass++;
        nchk++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL rst_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); else npass++;
        reset = 1'b1;
        step();
        nchk++; if (req_ready !== 1'b1)   $display("FAIL post_rst_ready: got %b want 1", req_ready); else npass++;
    endtask

    task automatic test_load_word();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        issue(0, 0, 3'd2, 32'd0, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (lat !== 2)           $display("FAIL lw_latency: got %0d want 2", lat); else npass++;
        nchk++; if (rd !== 32'h10080402) $display("FAIL lw_rdata: got %h want 10080402", rd); else npass++;
        nchk++; if (er !== 1'b0)         $display("FAIL lw_err: got %b want 0", er); else npass++;
        nchk++; if (sre !== 1'b1 || swe !== 1'b0) $display("FAIL lw_mem_en: got re=%b we=%b want 1/0", sre, swe); else npass++;
        nchk++; if (req_ready !== 1'b1)  $display("FAIL lw_back_idle: got %b want 1", req_ready); else npass++;
    endtask

    task automatic test_load_extend();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        mem[3] = 8'h80;
        issue(0, 0, 3'd0, 32'd3, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_sext: got %h want FFFFFF80", rd); else npass++;
        issue(0, 0, 3'd4, 32'd3, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (rd !== 32'h00000080) $display("FAIL lbu_zext: got %h want 00000080", rd); else npass++;
        issue(0, 0, 3'd1, 32'd2, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (rd !== 32'hFFFF8008) $display("FAIL lh_sext: got %h want FFFF8008", rd); else npass++;
        issue(0, 0, 3'd5, 32'd2, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (rd !== 32'h00008008) $display("FAIL lhu_zext: got %h want 00008008", rd); else npass++;
        issue(0, 0, 3'd2, 32'd1, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (rd !== 32'h00800804 || er !== 1'b0) $display("FAIL lw_unaligned: got %h err=%b want 00800804 err=0", rd, er); else npass++;
        mem[3] = 8'h10;
    endtask

    task automatic test_store();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        issue(0, 1, 3'd0, 32'd1, 32'h123456AB, lat, rd, er, sre, swe, sb);
        nchk++; if (lat !== 3)                $display("FAIL sb_latency: got %0d want 3", lat); else npass++;
        nchk++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL sb_resp: got %h err=%b want 0 err=0", rd, er); else npass++;
        nchk++; if (word_at(0) !== 32'h1008AB02) $display("FAIL sb_mem: got %h want 1008AB02", word_at(0)); else npass++;
        nchk++; if (sb !== 1'b0)              $display("FAIL sb_re_we_excl: got both=%b want 0", sb); else npass++;
        mem[10] = 8'h55; mem[11] = 8'h66;
        issue(0, 1, 3'd1, 32'd8, 32'hDEADBEEF, lat, rd, er, sre, swe, sb);
        nchk++; if (lat !== 3)                $display("FAIL sh_latency: got %0d want 3", lat); else npass++;
        nchk++; if (word_at(8) !== 32'h6655BEEF) $display("FAIL sh_mem: got %h want 6655BEEF", word_at(8)); else npass++;
        issue(0, 1, 3'd2, 32'd12, 32'hCAFEF00D, lat, rd, er, sre, swe, sb);
        nchk++; if (lat !== 2)                $display("FAIL sw_latency: got %0d want 2", lat); else npass++;
        nchk++; if (word_at(12) !== 32'hCAFEF00D) $display("FAIL sw_mem: got %h want CAFEF00D", word_at(12)); else npass++;
        nchk++; if (sre !== 1'b0)             $display("FAIL sw_no_read: got re=%b want 0", sre); else npass++;
        nchk++; if (mem_addr !== 32'd12 || mem_wdata !== 32'hCAFEF00D) $display("FAIL sw_bus_hold: got addr=%h wdata=%h want c/CAFEF00D", mem_addr, mem_wdata); else npass++;
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        issue(0, 0, 3'd2, 32'd1021, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || lat !== 1) $display("FAIL lw_1021_err: got err=%b lat=%0d want 1/1", er, lat); else npass++;
        nchk++; if (rd !== 32'h0 || sre !== 1'b0 || swe !== 1'b0) $display("FAIL lw_1021_quiet: got rd=%h re=%b we=%b want 0/0/0", rd, sre, swe); else npass++;
        nchk++; if (mem_addr !== 32'd12) $display("FAIL err_addr_hold: got %h want c", mem_addr); else npass++;
        mem[1020] = 8'hA1; mem[1021] = 8'hB2; mem[1022] = 8'hC3; mem[1023] = 8'hD4;
        issue(0, 0, 3'd2, 32'd1020, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b0 || rd !== 32'hD4C3B2A1) $display("FAIL lw_1020_edge: got err=%b rd=%h want 0/D4C3B2A1", er, rd); else npass++;
        issue(0, 0, 3'd2, 32'hFFFFFFFE, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || lat !== 1) $display("FAIL lw_wrap_err: got err=%b lat=%0d want 1/1", er, lat); else npass++;
        issue(0, 0, 3'd3, 32'd0, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || sre !== 1'b0) $display("FAIL ld_f3_3_err: got err=%b re=%b want 1/0", er, sre); else npass++;
        issue(0, 0, 3'd6, 32'd0, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1) $display("FAIL ld_f3_6_err: got err=%b want 1", er); else npass++;
        issue(0, 1, 3'd3, 32'd0, 32'hFFFFFFFF, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || swe !== 1'b0 || word_at(0) !== 32'h1008AB02) $display("FAIL st_f3_3_err: got err=%b we=%b word=%h want 1/0/1008AB02", er, swe, word_at(0)); else npass++;
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        issue(1, 0, 3'd2, 32'd2, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || lat !== 1) $display("FAIL mis_lw2: got err=%b lat=%0d want 1/1", er, lat); else npass++;
        issue(1, 1, 3'd1, 32'd1, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b1 || swe !== 1'b0) $display("FAIL mis_sh1: got err=%b we=%b want 1/0", er, swe); else npass++;
        issue(1, 0, 3'd2, 32'd4, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b0 || lat !== 2) $display("FAIL mis_lw4_ok: got err=%b lat=%0d want 0/2", er, lat); else npass++;
        issue(1, 0, 3'd0, 32'd3, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (er !== 1'b0) $display("FAIL mis_lb3_ok: got err=%b want 0", er); else npass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er; bit sre, swe, sb;
        resp_ready = 1'b0;
        issue(0, 0, 3'd2, 32'd0, 32'h0, lat, rd, er, sre, swe, sb);
        nchk++; if (lat !== 2 || rd !== 32'h1008AB02) $display("FAIL bp_first: got lat=%0d rd=%h want 2/1008AB02", lat, rd); else npass++;
        for (int i = 0; i < 5; i++) begin
            step();
            nchk++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1008AB02 || req_ready !== 1'b0 || resp_err !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b rd=%h rdy=%b err=%b want 1/1008AB02/0/0", i, resp_valid, resp_rdata, req_ready, resp_err);
            else npass++;
        end
        resp_ready = 1'b1;
        step();
        nchk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_release: got rdy=%b v=%b want 1/0", req_ready, resp_valid); else npass++;
    endtask

    task automatic test_reset_in_write();
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        req_store = 1'b1; req_funct3 = 3'd1; req_addr = 32'd4; req_wdata = 32'h0000BEEF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        nchk++; if (mem_re !== 1'b1) $display("FAIL rw_rmw_read: got re=%b want 1", mem_re); else npass++;
        step();
        nchk++; if (mem_we !== 1'b1 || mem_wdata !== 32'h4433BEEF) $display("FAIL rw_write_phase: got we=%b wdata=%h want 1/4433BEEF", mem_we, mem_wdata); else npass++;
        reset = 1'b0;
        #1;
        nchk++; if (mem_we !== 1'b0) $display("FAIL rw_we_drop: got %b want 0", mem_we); else npass++;
        step();
        reset = 1'b1;
        #1;
        nchk++; if (word_at(4) !== 32'h44332211) $display("FAIL rw_mem_kept: got %h want 44332211", word_at(4)); else npass++;
        nchk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL rw_idle: got rdy=%b v=%b want 1/0", req_ready, resp_valid); else npass++;
    endtask

    initial begin
        nchk = 0; npass = 0;
        reset = 1'b0; req_valid = 1'b0; a_req_valid = 1'b0; resp_ready = 1'b1;
        req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h02; mem[1] = 8'h04; mem[2] = 8'h08; mem[3] = 8'h10;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store();
        test_errors();
        test_misaligned();
        test_backpressure();
        test_reset_in_write();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

`default_nettype wire
